// File: rtl/ov5640_ddr_axi_wr_if.sv
// AXI4 write-only bus (AW/W/B) between the camera write master and the DDR controller.
`default_nettype none

interface ov5640_ddr_axi_wr_if;
  logic [3:0]   m_axi_awid;
  logic [31:0]  m_axi_awaddr;
  logic [7:0]   m_axi_awlen;
  logic [2:0]   m_axi_awsize;
  logic [1:0]   m_axi_awburst;
  logic         m_axi_awvalid;
  logic         m_axi_awready;
  logic [127:0] m_axi_wdata;
  logic [15:0]  m_axi_wstrb;
  logic         m_axi_wlast;
  logic         m_axi_wvalid;
  logic         m_axi_wready;
  logic [1:0]   m_axi_bresp;
  logic         m_axi_bvalid;
  logic         m_axi_bready;

  modport master (
    output m_axi_awid, m_axi_awaddr, m_axi_awlen, m_axi_awsize, m_axi_awburst, m_axi_awvalid,
    output m_axi_wdata, m_axi_wstrb, m_axi_wlast, m_axi_wvalid, m_axi_bready,
    input  m_axi_awready, m_axi_wready, m_axi_bresp, m_axi_bvalid
  );

  modport slave (
    input  m_axi_awid, m_axi_awaddr, m_axi_awlen, m_axi_awsize, m_axi_awburst, m_axi_awvalid,
    input  m_axi_wdata, m_axi_wstrb, m_axi_wlast, m_axi_wvalid, m_axi_bready,
    output m_axi_awready, m_axi_wready, m_axi_bresp, m_axi_bvalid
  );
endinterface

`default_nettype wire

// File: rtl/ov5640_ddr_axi_wr.sv
// ov5640_ddr_axi_wr: splits beat-count commands into 4 KB-safe INCR bursts and writes
// them over AXI4 with one burst outstanding.  Rev 1.0
`default_nettype none

module ov5640_ddr_axi_wr #(
  parameter int         MAX_BURST = 16,
  parameter logic [3:0] AXI_ID    = 4'd0
) (
  input  wire logic         axi_clk,
  input  wire logic         axi_rst_n,
  input  wire logic [31:0]  cmd_addr,
  input  wire logic [31:0]  cmd_len,
  input  wire logic         cmd_valid,
  output logic              cmd_ready,
  input  wire logic [127:0] s_data,
  input  wire logic         s_data_valid,
  output logic              s_data_ready,
  input  wire logic         s_data_last,
  ov5640_ddr_axi_wr_if.master m_axi,
  output logic              busy,
  output logic              done,
  output logic              err
);

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_AW = 2'd1, S_W = 2'd2, S_B = 2'd3} state_t;

  localparam logic [8:0] C_MAX = 9'(MAX_BURST);

  state_t      r_state;
  logic [31:0] r_addr;
  logic [31:0] r_rem;
  logic [8:0]  r_beats;
  logic [8:0]  r_cnt;
  logic        r_cmd_ready;
  logic        r_awvalid;
  logic        r_bready;
  logic        r_busy;
  logic        r_done;
  logic        r_err;

  logic [8:0]  w_room;
  logic [8:0]  w_cap;
  logic [8:0]  w_beats;
  logic [8:0]  w_beats_m1;
  logic        w_in_w;
  logic        w_whs;
  logic        w_wlast;
  logic        w_final;
  logic        w_unused;

  // Burst size comes from registered address/remainder, so it is stable while awvalid waits.
  assign w_room     = 9'd256 - {1'b0, r_addr[11:4]};
  assign w_cap      = (w_room < C_MAX) ? w_room : C_MAX;
  assign w_beats    = ({1'b0, r_rem} < {24'd0, w_cap}) ? r_rem[8:0] : w_cap;
  assign w_beats_m1 = w_beats - 9'd1;

  assign w_in_w  = (r_state == S_W);
  assign w_whs   = w_in_w & s_data_valid & m_axi.m_axi_wready;
  assign w_wlast = w_in_w & (r_cnt == (r_beats - 9'd1));
  assign w_final = (r_rem == {23'd0, r_beats});
  assign w_unused = ^cmd_addr[3:0];

  assign cmd_ready    = r_cmd_ready;
  assign busy         = r_busy;
  assign done         = r_done;
  assign err          = r_err;
  assign s_data_ready = w_in_w & m_axi.m_axi_wready;

  assign m_axi.m_axi_awid    = AXI_ID;
  assign m_axi.m_axi_awaddr  = r_addr;
  assign m_axi.m_axi_awlen   = (r_state == S_AW) ? w_beats_m1[7:0] : 8'h00;
  assign m_axi.m_axi_awsize  = 3'b100;
  assign m_axi.m_axi_awburst = 2'b01;
  assign m_axi.m_axi_awvalid = r_awvalid;
  assign m_axi.m_axi_wdata   = s_data;
  assign m_axi.m_axi_wstrb   = 16'hFFFF;
  assign m_axi.m_axi_wlast   = w_wlast;
  assign m_axi.m_axi_wvalid  = w_in_w & s_data_valid;
  assign m_axi.m_axi_bready  = r_bready;

  always_ff @(posedge axi_clk or negedge axi_rst_n) begin
    if (!axi_rst_n) begin
      r_state     <= S_IDLE;
      r_addr      <= 32'd0;
      r_rem       <= 32'd0;
      r_beats     <= 9'd0;
      r_cnt       <= 9'd0;
      r_cmd_ready <= 1'b0;
      r_awvalid   <= 1'b0;
      r_bready    <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_err       <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          r_cmd_ready <= 1'b1;
          if (cmd_valid && r_cmd_ready) begin
            r_addr <= {cmd_addr[31:4], 4'h0};
            r_rem  <= cmd_len;
            r_err  <= 1'b0;
            if (cmd_len == 32'd0) begin
              r_done <= 1'b1;
            end else begin
              r_cmd_ready <= 1'b0;
              r_awvalid   <= 1'b1;
              r_busy      <= 1'b1;
              r_state     <= S_AW;
            end
          end
        end
        S_AW: begin
          if (m_axi.m_axi_awready) begin
            r_awvalid <= 1'b0;
            r_beats   <= w_beats;
            r_cnt     <= 9'd0;
            r_state   <= S_W;
          end
        end
        S_W: begin
          if (w_whs) begin
            r_cnt <= r_cnt + 9'd1;
            // The last flag must coincide exactly with the command's final beat.
            if (s_data_last != (w_wlast && w_final)) begin
              r_err <= 1'b1;
            end
            if (w_wlast) begin
              r_addr   <= r_addr + {19'd0, r_beats, 4'h0};
              r_rem    <= r_rem - {23'd0, r_beats};
              r_bready <= 1'b1;
              r_state  <= S_B;
            end
          end
        end
        S_B: begin
          if (m_axi.m_axi_bvalid) begin
            r_bready <= 1'b0;
            if (m_axi.m_axi_bresp != 2'b00) begin
              r_err <= 1'b1;
            end
            if (r_rem != 32'd0) begin
              r_awvalid <= 1'b1;
              r_state   <= S_AW;
            end else begin
              r_done      <= 1'b1;
              r_busy      <= 1'b0;
              r_cmd_ready <= 1'b1;
              r_state     <= S_IDLE;
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: doc/ov5640_ddr_axi_wr.md
# ov5640_ddr_axi_wr

AXI4 write master directly downstream of the camera-to-DDR write path. It consumes that stage's command stream (start address, length in 16-byte beats) and its 128-bit data stream with last flag. It splits each command into INCR bursts of at most MAX_BURST beats that never cross a 4 KB boundary, and drives the DDR controller's AXI4 AW/W/B channels, one burst outstanding at a time.

## Interface
- MAX_BURST, 16, maximum beats per AXI burst; power of two, 1..256.
- AXI_ID, 0, constant value driven on m_axi_awid (4 bits).

- axi_clk  in  1  single clock for all logic.
- axi_rst_n  in  1  asynchronous, active-low reset.
- cmd_addr  in  32  command start byte address; bits [3:0] ignored and treated as 0.
- cmd_len  in  32  command length in 16-byte beats.
- cmd_valid / cmd_ready  in / out  1  command handshake.
- s_data  in  128  write data.
- s_data_valid / s_data_ready  in / out  1  data handshake.
- s_data_last  in  1  marks the final beat of a command's data.
- m_axi_awid  out  4  equals AXI_ID.
- m_axi_awaddr  out  32  burst address.
- m_axi_awlen  out  8  burst beats minus 1.
- m_axi_awsize  out  3  constant 3'b100.
- m_axi_awburst  out  2  constant 2'b01.
- m_axi_awvalid / m_axi_awready  out / in  1  AW handshake.
- m_axi_wdata  out  128  equals s_data.
- m_axi_wstrb  out  16  constant all ones.
- m_axi_wlast  out  1  final beat of the current burst.
- m_axi_wvalid / m_axi_wready  out / in  1  W handshake.
- m_axi_bresp  in  2  write response.
- m_axi_bvalid / m_axi_bready  in / out  1  B handshake.
- busy  out  1  high from command acceptance until done.
- done  out  1  one-cycle pulse when a command completes.
- err  out  1  sticky error flag; cleared when the next command is accepted.

## Operation
- States: IDLE, AW, W, B.
- IDLE
  - cmd_ready=1.
  - On handshake, latch addr = {cmd_addr[31:4],4'h0} and rem = cmd_len, and clear err.
  - If cmd_len==0: done pulses the next cycle and the block stays in IDLE.
  - Otherwise go to AW.
- AW
  - beats = min(rem, MAX_BURST, 256 − addr[11:4]); the 33-bit compare is done on registered values.
  - awaddr=addr, awlen=beats−1, awvalid=1.
  - On awready, go to W with beat counter = 0.
- W
  - wvalid=s_data_valid and s_data_ready=m_axi_wready. Both are combinational pass-throughs, and are 0 in every other state.
  - wlast = (beat counter == beats−1).
  - Each handshake increments the counter.
  - Handshake with wlast: go to B, with addr += beats·16 and rem −= beats.
- B
  - bready=1.
  - On bvalid: if bresp≠2'b00, set err.
  - Then, if rem≠0, go to AW; else pulse done and go to IDLE.
  - Remaining bursts are still issued after an error response.
- Last-flag check:
  - s_data_last on any accepted beat other than the command's final beat sets err.
  - A command's final beat accepted without s_data_last sets err.
  - Beats are never dropped or inserted either way; the count is governed by cmd_len only.
- Address arithmetic is 32-bit and wraps modulo 2^32.

## Timing
- Reset values: cmd_ready=0, awvalid=0, wvalid=0, wlast=0, bready=0, busy=0, done=0, err=0, awaddr=0, awlen=0. Constant outputs hold their constants.
- cmd_ready is registered and goes high the first cycle after reset release.
- Command accepted at cycle T: awvalid=1 at T+1.
- awvalid, awaddr and awlen are stable until awready; AXI valid-before-ready rules apply and no valid is dropped without a handshake.
- AW handshake at cycle A: the W state is entered at A+1, so the first beat can transfer at A+1.
- Last W handshake at cycle L: bready=1 at L+1.
- bvalid at cycle R: next awvalid at R+1, or done=1 and busy=0 at R+1.
- Asynchronous reset mid-burst forces all valids and ready signals low immediately, with no AXI cleanup. The system resets the DDR controller together with this block.

## Test plan
- Single burst: cmd_addr=0x1000_0000, cmd_len=16, MAX_BURST=16, always-ready slave -> one AW (awaddr 0x1000_0000, awlen 15), 16 W beats with wlast on beat 16, done pulse one cycle after bvalid, err=0.
- Split: cmd_addr=0x2000_0000, cmd_len=40 -> three bursts:
  - awaddr 0x2000_0000, awlen 15
  - awaddr 0x2000_0100, awlen 15
  - awaddr 0x2000_0200, awlen 7
  - Data is delivered in order.
- 4 KB crossing: cmd_addr=0x0000_0FC0, cmd_len=8 -> bursts (0x0FC0, awlen 3) then (0x1000, awlen 3).
- Back-pressure: random gaps on s_data_valid, m_axi_wready, m_axi_awready and m_axi_bvalid with cmd_len=37 -> the 37 received words equal the sent words in order, no duplicates, and wlast appears exactly once per burst.
- Errors:
  - bresp=2'b10 on the 2nd of 3 bursts -> err=1, the third burst is still issued, done pulses, and err clears at the next cmd handshake.
  - s_data_last on beat 5 of a cmd_len=8 command -> err=1 and 8 beats are still written.
- Boundaries:
  - cmd_len=0 -> no AW and a done pulse at T+1.
  - axi_rst_n low during the W state -> awvalid, wvalid and bready are 0 in the same cycle, and cmd_ready=1 one cycle after release.
